// File: rtl/note_sequencer_pkg.sv
// Shared state encoding and default timing constants for the note sequencer.
package note_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LOAD = 3'd1,
    ST_PLAY = 3'd2,
    ST_GAP  = 3'd3,
    ST_DONE = 3'd4
  } state_t;

  localparam int unsigned DEF_BEAT_CLKS  = 12000;
  localparam int unsigned DEF_NOTE_BEATS = 4;
  localparam int unsigned DEF_GAP_BEATS  = 1;
  localparam int unsigned DEF_SEQ_LEN    = 10;

endpackage

// File: rtl/note_sequencer_tone_divider.sv
// Square-wave generator: toggles every half_per+1 enabled cycles; half_per=0 is a rest.
module tone_divider (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic [7:0] half_per,
  output logic       tone
);

  logic [7:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt  <= '0;
      tone <= 1'b0;
    end else if (!en || half_per == 8'd0) begin
      cnt  <= '0;
      tone <= 1'b0;
    end else if (cnt == half_per) begin
      cnt  <= '0;
      tone <= ~tone;
    end else begin
      cnt <= cnt + 8'd1;
    end
  end

endmodule

// File: rtl/note_sequencer.sv
// Steps through an external frequency table, sounding each entry for a fixed
// number of beats followed by a silent gap; optional looping.
module note_sequencer
  import note_seq_pkg::*;
#(
  parameter int unsigned BEAT_CLKS  = DEF_BEAT_CLKS,
  parameter int unsigned NOTE_BEATS = DEF_NOTE_BEATS,
  parameter int unsigned GAP_BEATS  = DEF_GAP_BEATS,
  parameter int unsigned SEQ_LEN    = DEF_SEQ_LEN
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       stop,
  input  logic       loop_en,
  output logic [3:0] db_addr,
  input  logic [7:0] db_entry,
  output logic       tone_out,
  output logic       busy,
  output logic       done
);

  localparam int unsigned MAX_BEATS = (NOTE_BEATS > GAP_BEATS) ? NOTE_BEATS : GAP_BEATS;
  localparam int unsigned CLK_W     = (BEAT_CLKS > 1) ? $clog2(BEAT_CLKS) : 1;
  localparam int unsigned BEAT_W    = (MAX_BEATS > 1) ? $clog2(MAX_BEATS) : 1;

  state_t            state;
  logic [7:0]        freq_reg;
  logic [CLK_W-1:0]  clk_cnt;
  logic [BEAT_W-1:0] beat_cnt;
  logic              last_clk;
  logic              play_end;
  logic              gap_end;
  logic              tone_en;

  always_comb begin
    last_clk = (clk_cnt == CLK_W'(BEAT_CLKS - 1));
    play_end = last_clk && (beat_cnt == BEAT_W'(NOTE_BEATS - 1));
    gap_end  = last_clk && (beat_cnt == BEAT_W'(GAP_BEATS - 1));
    // Dropping enable on the final PLAY cycle lets the divider clear the tone
    // on the same edge that enters GAP, keeping tone_out registered and silent there.
    tone_en  = (state == ST_PLAY) && !play_end && !stop;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      db_addr  <= '0;
      freq_reg <= '0;
      clk_cnt  <= '0;
      beat_cnt <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else if (stop) begin
      state    <= ST_IDLE;
      db_addr  <= '0;
      clk_cnt  <= '0;
      beat_cnt <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            state   <= ST_LOAD;
            db_addr <= '0;
            busy    <= 1'b1;
            done    <= 1'b0;
          end
        end
        ST_LOAD: begin
          freq_reg <= db_entry;
          clk_cnt  <= '0;
          beat_cnt <= '0;
          state    <= ST_PLAY;
        end
        ST_PLAY, ST_GAP: begin
          if ((state == ST_PLAY) ? play_end : gap_end) begin
            clk_cnt  <= '0;
            beat_cnt <= '0;
            if (state == ST_PLAY) begin
              state <= ST_GAP;
            end else if (db_addr < 4'(SEQ_LEN - 1)) begin
              db_addr <= db_addr + 4'd1;
              state   <= ST_LOAD;
            end else if (loop_en) begin
              db_addr <= '0;
              state   <= ST_LOAD;
            end else begin
              state <= ST_DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end
          end else if (last_clk) begin
            clk_cnt  <= '0;
            beat_cnt <= beat_cnt + BEAT_W'(1);
          end else begin
            clk_cnt <= clk_cnt + CLK_W'(1);
          end
        end
        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

  tone_divider u_tone (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (tone_en),
    .half_per (freq_reg),
    .tone     (tone_out)
  );

endmodule

// File: tb/tb_note_sequencer.sv
// Directed bench: 4-clock beats, 2-beat notes, 1-beat gaps, table {3,0,1}.
module tb_note_sequencer;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic       stop;
  logic       loop_en;
  logic [3:0] db_addr;
  logic [7:0] db_entry;
  logic       tone_out;
  logic       busy;
  logic       done;

  int n_tests = 0;
  int n_fail  = 0;

  // Per-entry tone over one 13-cycle slot: bit 0 = LOAD, bits 1..8 = PLAY, 9..12 = GAP
  logic [12:0] pat [3] = '{13'b0000111100000, 13'b0000000000000, 13'b0000110011000};

  note_sequencer #(
    .BEAT_CLKS  (4),
    .NOTE_BEATS (2),
    .GAP_BEATS  (1),
    .SEQ_LEN    (3)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .stop     (stop),
    .loop_en  (loop_en),
    .db_addr  (db_addr),
    .db_entry (db_entry),
    .tone_out (tone_out),
    .busy     (busy),
    .done     (done)
  );

  always_comb begin
    case (db_addr)
      4'd0:    db_entry = 8'd3;
      4'd1:    db_entry = 8'd0;
      4'd2:    db_entry = 8'd1;
      default: db_entry = 8'd0;
    endcase
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, " busy"}, 32'(busy), 32'd0);
    chk({tag, " done"}, 32'(done), 32'd0);
    chk({tag, " addr"}, 32'(db_addr), 32'd0);
    chk({tag, " tone"}, 32'(tone_out), 32'd0);
  endtask

  // Checks cycles c0..c0+n-1 of a running sequence (c=0 is LOAD of entry 0), one tick each.
  task automatic walk(input int c0, input int n);
    int cc;
    int e;
    int p;
    for (int c = c0; c < c0 + n; c++) begin
      cc = c % 39;
      e  = cc / 13;
      p  = cc % 13;
      chk($sformatf("busy c%0d", c), 32'(busy), 32'd1);
      chk($sformatf("done c%0d", c), 32'(done), 32'd0);
      chk($sformatf("addr c%0d", c), 32'(db_addr), 32'(e));
      chk($sformatf("tone c%0d", c), 32'(tone_out), 32'(pat[e][p]));
      tick();
    end
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; stop = 1'b0; loop_en = 1'b0;
    #3;
    chk_idle("reset");
    tick();
    rst_n = 1'b1;
    tick();
    chk_idle("after release");

    start = 1'b1; stop = 1'b1;
    tick();
    chk_idle("start+stop idle");
    tick();
    chk_idle("start+stop idle2");
    start = 1'b0; stop = 1'b0;

    // Single pass: done after 39 cycles
    start = 1'b1;
    tick();
    start = 1'b0;
    walk(0, 39);
    chk("pass done", 32'(done), 32'd1);
    chk("pass busy", 32'(busy), 32'd0);
    chk("pass addr", 32'(db_addr), 32'd2);
    chk("pass tone", 32'(tone_out), 32'd0);
    tick();
    chk("done holds", 32'(done), 32'd1);

    // Looping: three passes with no done
    loop_en = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    walk(0, 117);
    chk("loop wrap addr", 32'(db_addr), 32'd0);
    chk("loop wrap busy", 32'(busy), 32'd1);
    stop = 1'b1;
    tick();
    chk_idle("loop stop");
    stop = 1'b0; loop_en = 1'b0;

    // Stop mid-PLAY of entry 1, then restart from entry 0
    start = 1'b1;
    tick();
    start = 1'b0;
    walk(0, 17);
    stop = 1'b1;
    tick();
    chk_idle("stop entry1");
    stop = 1'b0;
    tick();
    tick();
    chk_idle("stay idle");
    start = 1'b1;
    tick();
    start = 1'b0;
    walk(0, 5);
    chk("restart tone high", 32'(tone_out), 32'd1);
    stop = 1'b1;
    tick();
    chk_idle("stop while tone high");
    stop = 1'b0;

    // Asynchronous reset mid-GAP of entry 1
    start = 1'b1;
    tick();
    start = 1'b0;
    walk(0, 23);
    chk("gap busy", 32'(busy), 32'd1);
    chk("gap addr", 32'(db_addr), 32'd1);
    #3;
    rst_n = 1'b0;
    #1;
    chk_idle("async reset");
    #2;
    rst_n = 1'b1;
    tick();
    chk_idle("post reset");
    start = 1'b1;
    tick();
    start = 1'b0;
    walk(0, 6);

    // Finish that run, then start held high: one restart at DONE only
    stop = 1'b1;
    tick();
    stop = 1'b0;
    start = 1'b1;
    tick();
    walk(0, 39);
    chk("held done", 32'(done), 32'd1);
    chk("held busy", 32'(busy), 32'd0);
    tick();
    chk("held restart busy", 32'(busy), 32'd1);
    chk("held restart done", 32'(done), 32'd0);
    chk("held restart addr", 32'(db_addr), 32'd0);
    tick();
    walk(1, 13);
    chk("held no rerun addr", 32'(db_addr), 32'd1);
    stop = 1'b1;
    tick();
    chk_idle("held stop");
    tick();
    chk_idle("held stop2");
    start = 1'b0; stop = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
